// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding-window generator: two line buffers plus a registered window over a raster pixel stream.
// Optional MATRIX_SOF_EN adds a `sof` input that resynchronises the frame position to row 0, col 0.
module matrix_3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
`ifdef MATRIX_SOF_EN
    input  logic              sof,
`endif
    input  logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              matrix_finish,
    output logic              pix_finish
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_pos;
    logic [ROW_W-1:0]  row_pos;
    logic              frame_start;
    logic              win_full;
    logic              win_last;
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_out;
    logic [DATA_W-1:0] lb2_out;

`ifdef MATRIX_SOF_EN
    assign frame_start = sof;
`else
    assign frame_start = 1'b0;
`endif

    // Position of the pixel on the bus; a start-of-frame pixel overrides the counters.
    always_comb begin
        col_pos  = frame_start ? '0 : col_cnt;
        row_pos  = frame_start ? '0 : row_cnt;
        win_full = (row_pos >= ROW_TWO) && (col_pos >= COL_TWO);
        win_last = (row_pos == ROW_LAST) && (col_pos == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_valid) begin
            if (col_pos == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_pos == ROW_LAST) ? '0 : row_pos + ROW_W'(1);
            end else begin
                col_cnt <= col_pos + COL_W'(1);
                row_cnt <= row_pos;
            end
        end
    end

    // Line buffers are never cleared: a window is only flagged once rows r-2 and r-1 of this frame have passed through.
    assign lb1_out = lb1[IMG_WIDTH-1];
    assign lb2_out = lb2[IMG_WIDTH-1];

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[0] <= pix_data;
            lb2[0] <= lb1_out;
            for (int i = 1; i < IMG_WIDTH; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
        end
    end

    // Window registers and strobes: one cycle after pixel acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_p11    <= '0;
            matrix_p12    <= '0;
            matrix_p13    <= '0;
            matrix_p21    <= '0;
            matrix_p22    <= '0;
            matrix_p23    <= '0;
            matrix_p31    <= '0;
            matrix_p32    <= '0;
            matrix_p33    <= '0;
            matrix_finish <= 1'b0;
            pix_finish    <= 1'b0;
        end else begin
            matrix_finish <= pix_valid && win_full;
            pix_finish    <= pix_valid && win_full && win_last;
            if (pix_valid) begin
                matrix_p11 <= matrix_p12;
                matrix_p12 <= matrix_p13;
                matrix_p13 <= lb2_out;
                matrix_p21 <= matrix_p22;
                matrix_p22 <= matrix_p23;
                matrix_p23 <= lb1_out;
                matrix_p31 <= matrix_p32;
                matrix_p32 <= matrix_p33;
                matrix_p33 <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Self-checking bench for matrix_3x3_gen on a 4x4 image; exercises the sof path when MATRIX_SOF_EN is defined.
module tb_matrix_3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_valid = 1'b0;
    logic       sof_drv = 1'b0;
    logic [7:0] pix_data = '0;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       matrix_finish, pix_finish;
    logic [71:0] dut_win;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_mf   = 0;
    int cnt_pf   = 0;

    matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
`ifdef MATRIX_SOF_EN
        .sof(sof_drv),
`endif
        .pix_data(pix_data),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .matrix_finish(matrix_finish),
        .pix_finish(pix_finish)
    );

    always #5 clk = ~clk;

    assign dut_win = {matrix_p11, matrix_p12, matrix_p13,
                      matrix_p21, matrix_p22, matrix_p23,
                      matrix_p31, matrix_p32, matrix_p33};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [71:0] win(input int a, b, c, d, e, f, g, h, i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    // Frame model: position from the count of accepted pixels, window read from a 2-D image array.
    logic [7:0]  img [H][W];
    int          k = 0;
    logic        model_ready = 1'b0;
    logic        win_known = 1'b0;
    logic        exp_mf = 1'b0;
    logic        exp_pf = 1'b0;
    logic [71:0] exp_win = '0;

    always @(posedge clk) begin
        int r, c;
        if (rst) begin
            model_ready = 1'b1;
            k = 0;
            exp_mf = 1'b0;
            exp_pf = 1'b0;
            exp_win = '0;
            win_known = 1'b1;
        end else if (pix_valid) begin
            if (sof_drv) k = 0;
            r = k / W;
            c = k % W;
            img[r][c] = pix_data;
            if (r >= 2 && c >= 2) begin
                exp_mf = 1'b1;
                exp_pf = (r == H-1) && (c == W-1);
                exp_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                           img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                           img[r][c-2],   img[r][c-1],   img[r][c]};
                win_known = 1'b1;
            end else begin
                exp_mf = 1'b0;
                exp_pf = 1'b0;
                win_known = 1'b0;
            end
            k = (k + 1) % (W * H);
        end else begin
            exp_mf = 1'b0;
            exp_pf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("model_matrix_finish", 72'(matrix_finish), 72'(exp_mf));
            chk("model_pix_finish", 72'(pix_finish), 72'(exp_pf));
            if (win_known) chk("model_window", dut_win, exp_win);
            if (matrix_finish === 1'b1) cnt_mf++;
            if (pix_finish === 1'b1) cnt_pf++;
        end
    end

    task automatic send(input int d, input logic s = 1'b0);
        pix_valid = 1'b1;
        pix_data  = 8'(d);
        sof_drv   = s;
        @(negedge clk);
        pix_valid = 1'b0;
        sof_drv   = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send(v);
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        idle(2);
        cnt_mf = 0;
        cnt_pf = 0;
        rst = 1'b0;
    endtask

    task automatic frame_checks(input int base);
        send_range(base, base + 9);
        chk("no_strobe_pix9", 72'(matrix_finish), 72'(0));
        send(base + 10);
        chk("first_strobe", 72'(matrix_finish), 72'(1));
        chk("first_window", dut_win, win(base, base+1, base+2, base+4, base+5, base+6, base+8, base+9, base+10));
        chk("first_pix_finish", 72'(pix_finish), 72'(0));
        send_range(base + 11, base + 14);
        send(base + 15);
        chk("last_window", dut_win, win(base+5, base+6, base+7, base+9, base+10, base+11, base+13, base+14, base+15));
        chk("last_pix_finish", 72'(pix_finish), 72'(1));
    endtask

    initial begin
        idle(1);
        do_reset();
        chk("reset_window", dut_win, '0);
        chk("reset_strobes", 72'({matrix_finish, pix_finish}), 72'(0));

        // Contiguous frame 0..15
        frame_checks(0);
        idle(2);
        chk("s1_strobe_count", 72'(cnt_mf), 72'(4));
        chk("s1_pix_finish_count", 72'(cnt_pf), 72'(1));

        // Three-cycle gap between pixels 10 and 11
        do_reset();
        send_range(0, 10);
        for (int g = 0; g < 3; g++) begin
            idle(1);
            chk("gap_no_strobe", 72'(matrix_finish), 72'(0));
            chk("gap_hold", dut_win, win(0, 1, 2, 4, 5, 6, 8, 9, 10));
        end
        send(11);
        chk("gap_next_strobe", 72'(matrix_finish), 72'(1));
        chk("gap_next_window", dut_win, win(1, 2, 3, 5, 6, 7, 9, 10, 11));
        send_range(12, 15);
        idle(2);
        chk("s2_strobe_count", 72'(cnt_mf), 72'(4));

        // Back-to-back frames
        do_reset();
        send_range(0, 15);
        frame_checks(100);
        idle(2);
        chk("s3_strobe_count", 72'(cnt_mf), 72'(8));
        chk("s3_pix_finish_count", 72'(cnt_pf), 72'(2));

        // Reset mid-frame after pixel 9
        do_reset();
        send_range(0, 9);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midreset_window", dut_win, '0);
        frame_checks(0);
        idle(2);
        chk("s4_strobe_count", 72'(cnt_mf), 72'(4));
        chk("s4_pix_finish_count", 72'(cnt_pf), 72'(1));

`ifdef MATRIX_SOF_EN
        // Partial frame discarded by sof
        do_reset();
        send_range(50, 56);
        send(0, 1'b1);
        send_range(1, 9);
        chk("sof_no_strobe_pix9", 72'(matrix_finish), 72'(0));
        send(10);
        chk("sof_first_window", dut_win, win(0, 1, 2, 4, 5, 6, 8, 9, 10));
        send_range(11, 15);
        chk("sof_last_window", dut_win, win(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("sof_pix_finish", 72'(pix_finish), 72'(1));
        idle(2);
        chk("s5_strobe_count", 72'(cnt_mf), 72'(4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
